// File: rtl/mul_add_pkg.sv
// Shared definitions for the multiply-accumulate unit and its paired restoring divider.
// Both blocks take their default operand width from here so they always match.
package mul_add_pkg;

  localparam int MUL_ADD_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : mul_add_pkg

// File: rtl/mul_add_seq.sv
// Sequential shift-and-add multiply-accumulate: a_out = q_in * b_in + r_in (unsigned).
// One multiplier bit per clock, LSB first; fixed WIDTH-cycle RUN phase, then a one-cycle done pulse.
module mul_add_seq
  import mul_add_pkg::*;
#(
  parameter int WIDTH = MUL_ADD_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     q_in,
  input  logic [WIDTH-1:0]     b_in,
  input  logic [WIDTH-1:0]     r_in,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   a_out,
  output logic                 overflow
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   md_q, md_d;
  logic [WIDTH-1:0]     mq_q, mq_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   a_out_q, a_out_d;
  logic                 ovf_q, ovf_d;
  logic [2*WIDTH-1:0]   acc_step;

  // The accumulator cannot wrap: the largest result is 2^(2W) - 2^W.
  assign acc_step = mq_q[0] ? (acc_q + md_q) : acc_q;

  always_comb begin
    // NOTE: every next-state signal gets a hold default first so no path infers a latch.
    state_d = state_q;
    acc_d   = acc_q;
    md_d    = md_q;
    mq_d    = mq_q;
    cnt_d   = cnt_q;
    a_out_d = a_out_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = {{WIDTH{1'b0}}, r_in};
          md_d    = {{WIDTH{1'b0}}, b_in};
          mq_d    = q_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        acc_d = acc_step;
        md_d  = md_q << 1;
        mq_d  = mq_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          a_out_d = acc_step;
          ovf_d   = |acc_step[2*WIDTH-1:WIDTH];
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      md_q    <= '0;
      mq_q    <= '0;
      cnt_q   <= '0;
      a_out_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      md_q    <= md_d;
      mq_q    <= mq_d;
      cnt_q   <= cnt_d;
      a_out_q <= a_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign a_out    = a_out_q;
  assign overflow = ovf_q;

endmodule : mul_add_seq

// File: tb/tb_mul_add_seq.sv
// Self-checking bench for mul_add_seq: directed corner cases plus randomized operands
// and divider round trips, all checked against plain-arithmetic expectations.
module tb_mul_add_seq;
  import mul_add_pkg::*;

  localparam int W      = MUL_ADD_WIDTH;
  localparam int BUDGET = 4 * W;

  logic             clock;
  logic             reset_n;
  logic             start;
  logic [W-1:0]     q_in, b_in, r_in;
  logic             busy, done, overflow;
  logic [2*W-1:0]   a_out;

  int n_checks = 0;
  int n_fail   = 0;

  mul_add_seq dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .q_in     (q_in),
    .b_in     (b_in),
    .r_in     (r_in),
    .busy     (busy),
    .done     (done),
    .a_out    (a_out),
    .overflow (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mac(input logic [W-1:0] q, b, r);
    logic [2*W-1:0] wq, wb, wr;
    wq = {{W{1'b0}}, q};
    wb = {{W{1'b0}}, b};
    wr = {{W{1'b0}}, r};
    return wq * wb + wr;
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] q, b, r);
    logic [2*W-1:0] v;
    v = ref_mac(q, b, r);
    return (v >= (64'd1 << W));
  endfunction

  // Drive one request on a falling edge; returns just after the accepting rising edge.
  task automatic start_op(input logic [W-1:0] q, b, r);
    @(negedge clock);
    start = 1'b1;
    q_in  = q;
    b_in  = b;
    r_in  = r;
    @(negedge clock);
    start = 1'b0;
    q_in  = $urandom;
    b_in  = $urandom;
    r_in  = $urandom;
  endtask

  // Counts busy cycles until done is seen, bounded by BUDGET cycles.
  task automatic wait_done(input bit scramble, output int busy_cycles, output bit seen);
    int guard;
    busy_cycles = 0;
    guard       = 0;
    while (!done && guard < BUDGET) begin
      if (busy) busy_cycles++;
      if (scramble) begin
        q_in = $urandom;
        b_in = $urandom;
        r_in = $urandom;
      end
      @(negedge clock);
      guard++;
    end
    seen = done;
  endtask

  task automatic run_and_check(input string tag, input logic [W-1:0] q, b, r, input bit timing);
    int busy_cycles;
    bit seen;
    start_op(q, b, r);
    wait_done(1'b0, busy_cycles, seen);
    if (timing) begin
      check({tag, "_done_seen"}, 64'(seen), 64'd1);
      check({tag, "_latency"}, 64'(busy_cycles), 64'(W));
    end else if (!seen) begin
      check({tag, "_timeout"}, 64'(seen), 64'd1);
    end
    check({tag, "_a_out"}, a_out, ref_mac(q, b, r));
    if (timing) begin
      check({tag, "_overflow"}, 64'(overflow), 64'(ref_ovf(q, b, r)));
      @(negedge clock);
      check({tag, "_done_pulse"}, 64'(done), 64'd0);
    end else begin
      @(negedge clock);
    end
  endtask

  initial begin
    logic [W-1:0] q, b, r, a, q2, b2, r2;
    int busy_cycles;
    int done_count;
    bit seen;

    reset_n = 1'b0;
    start   = 1'b0;
    q_in    = '0;
    b_in    = '0;
    r_in    = '0;
    repeat (3) @(negedge clock);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_a_out", a_out, 64'd0);
    check("reset_overflow", 64'(overflow), 64'd0);
    reset_n = 1'b1;
    @(negedge clock);

    run_and_check("basic", 32'd7, 32'd3, 32'd2, 1'b1);
    check("basic_value", a_out, 64'd23);
    run_and_check("extreme", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    check("extreme_value", a_out, 64'hFFFF_FFFF_0000_0000);
    run_and_check("zero_b", 32'h1234_5678, 32'd0, 32'd5, 1'b1);
    check("zero_b_value", a_out, 64'd5);
    run_and_check("zero_q", 32'd0, 32'hDEAD_BEEF, 32'h8000_0000, 1'b1);
    run_and_check("ovf_edge", 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1);

    // Start held high with operands changing during RUN: one operation, E0 values only.
    q = 32'h0000_BEEF;
    b = 32'h0001_2345;
    r = 32'h0000_0077;
    @(negedge clock);
    start = 1'b1;
    q_in  = q;
    b_in  = b;
    r_in  = r;
    @(negedge clock);
    wait_done(1'b1, busy_cycles, seen);
    check("hold_done_seen", 64'(seen), 64'd1);
    check("hold_latency", 64'(busy_cycles), 64'(W));
    check("hold_a_out", a_out, ref_mac(q, b, r));
    q2 = 32'd1000;
    b2 = 32'd1000;
    r2 = 32'd1;
    q_in = q2;
    b_in = b2;
    r_in = r2;
    @(negedge clock);
    check("hold_idle_busy", 64'(busy), 64'd0);
    check("hold_idle_done", 64'(done), 64'd0);
    @(negedge clock);
    check("hold_second_accept", 64'(busy), 64'd1);
    start = 1'b0;
    wait_done(1'b0, busy_cycles, seen);
    check("hold_second_a_out", a_out, 64'd1000001);
    @(negedge clock);

    // Reset during RUN cycle 10 aborts the operation without a done pulse.
    start_op(32'h0F0F_0F0F, 32'h1111_1111, 32'd9);
    repeat (9) @(negedge clock);
    check("abort_was_busy", 64'(busy), 64'd1);
    reset_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_a_out", a_out, 64'd0);
    check("abort_overflow", 64'(overflow), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    done_count = 0;
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge clock);
      if (done || busy) done_count++;
    end
    check("abort_no_done", 64'(done_count), 64'd0);

    // Divider round trip: q = a / b, r = a % b must rebuild a.
    run_and_check("div_100_7", 32'd14, 32'd7, 32'd2, 1'b1);
    check("div_100_7_value", a_out, 64'd100);
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = $urandom;
      if ((i % 4) == 0) b = 32'($urandom_range(1, 255));
      if (b == 0) b = 32'd1;
      q = a / b;
      r = a % b;
      start_op(q, b, r);
      wait_done(1'b0, busy_cycles, seen);
      check("roundtrip_a", a_out, {{W{1'b0}}, a});
      if (overflow !== 1'b0) check("roundtrip_ovf", 64'(overflow), 64'd0);
      @(negedge clock);
    end

    // Unconstrained random multiply-accumulate with full timing checks.
    for (int i = 0; i < 60; i++) begin
      q = $urandom;
      b = $urandom;
      r = $urandom;
      if ((i % 5) == 1) q = q & 32'h0000_FFFF;
      run_and_check("random", q, b, r, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_mul_add_seq
